// File: rtl/nf10_rx_arb_pkg.sv
// Shared definitions for the RX port arbiter: FSM state encoding and
// packet-counter width.
package nf10_rx_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    FORWARD = 1'b1
  } arb_state_t;

  localparam int unsigned PKT_CNT_W = 32;

endpackage

// File: rtl/rx_port_arbiter_rr_select.sv
// Round-robin priority search: returns the first requesting port found
// scanning upward from (last_grant + 1) mod NUM_PORTS. Purely combinational.
module rr_select
  import nf10_rx_arb_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 4,
  localparam int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [IDX_W-1:0]     idx,
  output logic                 found
);

  logic [IDX_W-1:0] cand;

  // Scan candidates in rotating priority order; the first hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = IDX_W'((32'(last_grant) + 32'd1 + i) % NUM_PORTS);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_port_arbiter.sv
// Packet-level round-robin arbiter merging NUM_PORTS AXI-Stream RX ports
// into one output stream. A grant is held until tlast is accepted; each
// packet costs one idle arbitration cycle.
// Optional feature: define RX_PORT_ARBITER_PKT_CNT_EN to add per-port
// 32-bit accepted-packet counters on output pkt_count.
module rx_port_arbiter
  import nf10_rx_arb_pkg::*;
#(
  parameter  int unsigned NUM_PORTS      = 4,
  parameter  int unsigned AXI_DATA_WIDTH = 64,
  localparam int unsigned STRB_W         = AXI_DATA_WIDTH / 8,
  localparam int unsigned IDX_W          = $clog2(NUM_PORTS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS*STRB_W-1:0]         s_tstrb,
  input  logic [NUM_PORTS-1:0]                s_tvalid,
  input  logic [NUM_PORTS-1:0]                s_tlast,
  output logic [NUM_PORTS-1:0]                s_tready,
  output logic [AXI_DATA_WIDTH-1:0]           m_tdata,
  output logic [STRB_W-1:0]                   m_tstrb,
  output logic                                m_tvalid,
  output logic                                m_tlast,
  input  logic                                m_tready,
  output logic [IDX_W-1:0]                    grant_idx,
  output logic                                busy
`ifdef RX_PORT_ARBITER_PKT_CNT_EN
  ,
  output logic [NUM_PORTS*PKT_CNT_W-1:0]      pkt_count
`endif
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] last_grant_q;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             tlast_accept;

  rr_select #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_select (
    .req        (s_tvalid),
    .last_grant (last_grant_q),
    .idx        (sel_idx),
    .found      (sel_found)
  );

  assign tlast_accept = m_tvalid & m_tready & m_tlast;
  assign grant_idx    = grant_q;
  assign busy         = (state_q == FORWARD);

  // State register plus grant capture while arbitrating in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && sel_found) begin
        grant_q      <= sel_idx;
        last_grant_q <= sel_idx;
      end
    end
  end

  // Next-state: arbitrate in IDLE, hold the grant until tlast is accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sel_found)    state_d = FORWARD;
      FORWARD: if (tlast_accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output mux: only the granted port is connected, and only in FORWARD.
  always_comb begin
    m_tdata  = '0;
    m_tstrb  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state_q == FORWARD) begin
      m_tdata           = s_tdata[grant_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      m_tstrb           = s_tstrb[grant_q*STRB_W +: STRB_W];
      m_tvalid          = s_tvalid[grant_q];
      m_tlast           = s_tlast[grant_q];
      s_tready[grant_q] = m_tready;
    end
  end

`ifdef RX_PORT_ARBITER_PKT_CNT_EN
  logic [PKT_CNT_W-1:0] pkt_cnt_q [NUM_PORTS];

  // Count accepted tlast beats per port; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) pkt_cnt_q[i] <= '0;
    end else if (tlast_accept) begin
      pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign pkt_count[g*PKT_CNT_W +: PKT_CNT_W] = pkt_cnt_q[g];
  end
`endif

endmodule
